// File: rtl/intt_seq.sv
// intt_seq: sequential inverse number-theoretic transform over GF(P).
//
// Loads N coefficients x[j], computes y[i] = N^-1 * sum_j x[j] * W_INV^(i*j) mod P
// with one modular multiply-accumulate path, then streams y[0..N-1] out.
//
// Build option: define INTT_SCALE_EN to scale results by N_INV (true inverse).
// Without it, results are stored unscaled (N times the inverse transform) and
// the N_INV multiplier is not built. Cycle timing is the same in both builds.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   input coefficient valid
//   in_ready   accepting coefficients (LOAD only)
//   in_data    coefficient x[j], j = 0..N-1
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   result y[i], i = 0..N-1
//   out_last   high with y[N-1]
//   busy       high during COMPUTE and OUT
module intt_seq #(
  parameter int unsigned       N     = 8,
  parameter int unsigned       WIDTH = 32,
  parameter logic [WIDTH-1:0]  P     = 17,
  parameter logic [WIDTH-1:0]  W_INV = 9,
  parameter logic [WIDTH-1:0]  N_INV = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned      AW       = $clog2(N);
  localparam int unsigned      CW       = AW + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0]    CNT_END  = CW'(N);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUT} state_t;

  state_t state, state_next;

  logic [CW-1:0]    j, i, k;
  logic [WIDTH-1:0] acc, tw, step;
  logic [WIDTH-1:0] xbuf [N];
  logic [WIDTH-1:0] ybuf [N];

  logic             load_fire, out_fire;
  logic [WIDTH-1:0] load_val, acc_mac, tw_next, step_next, fin_val;
  logic [WIDTH:0]   mac_sum;

  function automatic logic [WIDTH-1:0] mulmod(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] prod;
    prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return WIDTH'(prod % {{WIDTH{1'b0}}, P});
  endfunction

  assign load_fire = (state == S_LOAD) && in_valid;
  assign out_fire  = (state == S_OUT) && out_ready;

  // Modular arithmetic. Both addends are < P, so one conditional subtract
  // performs the reduction of the WIDTH+1 bit sum.
  always_comb begin
    load_val  = in_data % P;
    mac_sum   = {1'b0, acc} + {1'b0, mulmod(xbuf[j[AW-1:0]], tw)};
    acc_mac   = (mac_sum >= {1'b0, P}) ? WIDTH'(mac_sum - {1'b0, P})
                                       : mac_sum[WIDTH-1:0];
    tw_next   = mulmod(tw, step);
    step_next = mulmod(step, W_INV);
`ifdef INTT_SCALE_EN
    fin_val   = mulmod(acc, N_INV);
`else
    fin_val   = acc;
`endif
  end

`ifndef INTT_SCALE_EN
  // N_INV has no role in the unscaled build; the reduction keeps it referenced.
  logic unused_n_inv;
  assign unused_n_inv = ^N_INV;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    state_next = S_LOAD;
      S_LOAD:    if (load_fire && j == CNT_LAST) state_next = S_COMPUTE;
      S_COMPUTE: if (j == CNT_END && i == CNT_LAST) state_next = S_OUT;
      S_OUT:     if (out_fire && k == CNT_LAST) state_next = S_LOAD;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset clears them
  // asynchronously and in_ready rises one clock after reset release.
  always_comb begin
    in_ready  = '0;
    out_valid = '0;
    out_data  = '0;
    out_last  = '0;
    busy      = '0;
    case (state)
      S_LOAD:    in_ready = '1;
      S_COMPUTE: busy = '1;
      S_OUT: begin
        busy      = '1;
        out_valid = '1;
        out_data  = ybuf[k[AW-1:0]];
        out_last  = (k == CNT_LAST);
      end
      default: ;
    endcase
  end

  // Counters and MAC state. Each output index i takes N MAC cycles
  // (j = 0..N-1) followed by one finalize cycle (j == N).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j    <= '0;
      i    <= '0;
      k    <= '0;
      acc  <= '0;
      tw   <= ONE;
      step <= ONE;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_fire) begin
            if (j == CNT_LAST) begin
              j    <= '0;
              i    <= '0;
              acc  <= '0;
              tw   <= ONE;
              step <= ONE;
            end else begin
              j <= j + CW'(1);
            end
          end
        end
        S_COMPUTE: begin
          if (j != CNT_END) begin
            acc <= acc_mac;
            tw  <= tw_next;
            j   <= j + CW'(1);
          end else begin
            acc  <= '0;
            tw   <= ONE;
            j    <= '0;
            step <= step_next;
            if (i == CNT_LAST) begin
              i <= '0;
              k <= '0;
            end else begin
              i <= i + CW'(1);
            end
          end
        end
        S_OUT: begin
          if (out_fire) begin
            if (k == CNT_LAST) begin
              k <= '0;
              j <= '0;
            end else begin
              k <= k + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Coefficient and result buffers hold no reset.
  always_ff @(posedge clk) begin
    if (load_fire) xbuf[j[AW-1:0]] <= load_val;
    if (state == S_COMPUTE && j == CNT_END) ybuf[i[AW-1:0]] <= fin_val;
  end

endmodule

// File: tb/tb_intt_seq.sv
// Self-checking bench for intt_seq (N=8, P=17, W_INV=9, N_INV=15).
// Expected results track the INTT_SCALE_EN build option.
module tb_intt_seq;

  typedef logic [31:0] vec_t [8];

`ifdef INTT_SCALE_EN
  localparam int unsigned SCL = 1;
`else
  localparam int unsigned SCL = 8;
`endif

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [31:0] in_data, out_data;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  intt_seq #(.N(8), .WIDTH(32), .P(17), .W_INV(9), .N_INV(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Forward NTT with omega = 2 mod 17 (independent of the DUT's inverse path).
  function automatic vec_t fwd_ntt(input vec_t x);
    vec_t r;
    int unsigned wi = 1;
    for (int ii = 0; ii < 8; ii++) begin
      int unsigned acc = 0;
      int unsigned t = 1;
      for (int jj = 0; jj < 8; jj++) begin
        acc = (acc + x[jj] * t) % 17;
        t = (t * wi) % 17;
      end
      r[ii] = acc;
      wi = (wi * 2) % 17;
    end
    return r;
  endfunction

  function automatic vec_t scaled(input vec_t v);
    vec_t r;
    for (int n = 0; n < 8; n++) r[n] = (v[n] * SCL) % 17;
    return r;
  endfunction

  // Called at a negedge in LOAD; returns at the negedge after the last handshake.
  task automatic send_frame(input string tag, input vec_t x);
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_data  = x[n];
      chk({tag, "_in_ready"}, in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Waits for the first out_valid, checking COMPUTE behaviour and latency.
  task automatic wait_out(input string tag, input bit pulse);
    int unsigned cyc = 1;
    while (!out_valid && cyc < 200) begin
      if (pulse) begin
        in_valid = cyc[0];
        in_data  = 32'd99;
      end
      chk({tag, "_cmp_in_ready"}, in_ready, 0);
      chk({tag, "_cmp_busy"}, busy, 1);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, cyc, 73);
  endtask

  // Drains the burst; abort_at < 8 stops (without handshaking) at that beat.
  task automatic get_frame(input string tag, input vec_t exp, input bit bp,
                           input int unsigned abort_at);
    int unsigned beat  = 0;
    int unsigned guard = 0;
    int unsigned stall = 0;
    while (beat < 8 && guard < 400) begin
      if (beat == abort_at)                 out_ready = 1'b0;
      else if (bp && beat == 3 && stall < 5) begin out_ready = 1'b0; stall++; end
      else if (bp)                          out_ready = 1'($urandom_range(0, 1));
      else                                  out_ready = 1'b1;
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_data"}, out_data, exp[beat]);
      chk({tag, "_last"}, out_last, (beat == 7) ? 32'd1 : 32'd0);
      chk({tag, "_out_in_ready"}, in_ready, 0);
      if (beat == abort_at) break;
      if (out_ready) beat++;
      guard++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, "_beats"}, beat, (abort_at < 8) ? abort_at : 8);
    if (abort_at >= 8) begin
      chk({tag, "_reload_ready"}, in_ready, 1);
      chk({tag, "_reload_busy"}, busy, 0);
    end
  endtask

  // Asserts reset at a negedge; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_rst_in_ready"}, in_ready, 0);
    chk({tag, "_rst_out_valid"}, out_valid, 0);
    chk({tag, "_rst_out_data"}, out_data, 0);
    chk({tag, "_rst_out_last"}, out_last, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk({tag, "_idle_in_ready"}, in_ready, 0);
    @(negedge clk);
    chk({tag, "_load_in_ready"}, in_ready, 1);
  endtask

  initial begin
    vec_t x_imp, x_big, x_one, x_rt1, x_rt2;
    vec_t e_imp, e_one, e_rt1, e_rt2;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    x_imp = '{32'd8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    x_big = '{32'd25, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    x_one = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    x_rt1 = '{32'd3, 32'd14, 32'd0, 32'd7, 32'd16, 32'd1, 32'd9, 32'd5};
    x_rt2 = '{32'd5, 32'd0, 32'd11, 32'd3, 32'd0, 32'd16, 32'd2, 32'd9};

    // Impulse 8 -> true INTT is all ones; constant ones -> [1,0,...,0].
    e_imp = scaled('{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1});
    e_one = scaled('{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
    e_rt1 = scaled(x_rt1);
    e_rt2 = scaled(x_rt2);

    @(negedge clk);
    do_reset("init");

    send_frame("impulse", x_imp);
    wait_out("impulse", 1'b0);
    get_frame("impulse", e_imp, 1'b0, 8);

    send_frame("const", x_one);
    wait_out("const", 1'b0);
    get_frame("const", e_one, 1'b0, 8);

    send_frame("roundtrip", fwd_ntt(x_rt1));
    wait_out("roundtrip", 1'b1);
    get_frame("roundtrip", e_rt1, 1'b0, 8);

    send_frame("backpress", fwd_ntt(x_rt2));
    wait_out("backpress", 1'b0);
    get_frame("backpress", e_rt2, 1'b1, 8);

    send_frame("oor", x_big);
    wait_out("oor", 1'b0);
    get_frame("oor", e_imp, 1'b0, 8);

    // Reset during COMPUTE, then a clean frame.
    send_frame("abort_cmp", x_rt1);
    repeat (20) @(negedge clk);
    chk("abort_cmp_busy", busy, 1);
    do_reset("abort_cmp");
    send_frame("after_cmp", x_one);
    wait_out("after_cmp", 1'b0);
    get_frame("after_cmp", e_one, 1'b0, 8);

    // Reset while beat 4 of the output burst is presented.
    send_frame("abort_out", fwd_ntt(x_rt2));
    wait_out("abort_out", 1'b0);
    get_frame("abort_out", e_rt2, 1'b0, 4);
    do_reset("abort_out");
    send_frame("after_out", x_imp);
    wait_out("after_out", 1'b0);
    get_frame("after_out", e_imp, 1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/intt_seq.md
# intt_seq

Sequential inverse number-theoretic transform (INTT) for the zk-SNARK polynomial datapath. It accepts N evaluation-domain coefficients over a valid/ready stream and computes y[i] = N⁻¹ · Σ_j x[j] · ω⁻ⁱʲ mod P with a single modular multiply-accumulate unit. It then streams the N results out with backpressure. It sits downstream of the forward NTT so that a forward/inverse round trip returns the original coefficients.

## Interface
- N, 8: transform length; power of two, 2..64.
- WIDTH, 32: data width in bits; P < 2^WIDTH.
- P, 17: prime modulus.
- W_INV, 9: ω⁻¹ mod P, the inverse of the primitive N-th root of unity.
- N_INV, 15: N⁻¹ mod P.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input coefficient valid.
- in_ready  output  1  block accepts input (LOAD state only).
- in_data  input  WIDTH  coefficient x[j], in order j = 0..N-1.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  result y[i], in order i = 0..N-1.
- out_last  output  1  high with y[N-1].
- busy  output  1  high in COMPUTE and OUT.

## Operation
- **States:** IDLE, LOAD, COMPUTE, OUT.
- **Reset (rst low):** state = IDLE; all counters = 0; acc = 0; tw = 1; step = 1. Outputs are 0: in_ready, out_valid, out_data, out_last, busy. Coefficient and result buffers are not cleared.
- **IDLE:** moves to LOAD on the next clock, unconditionally.
- **LOAD:**
  - in_ready = 1.
  - Each in_valid & in_ready handshake stores (in_data mod P) into xbuf[j], then j++.
  - The handshake with j = N-1 moves the block to COMPUTE. It also sets i = 0, j = 0, acc = 0, tw = 1, step = 1.
- **COMPUTE, MAC cycle (j < N):**
  - acc ← (acc + xbuf[j]·tw) mod P.
  - tw ← (tw·step) mod P.
  - j++.
- **COMPUTE, finalize cycle (after j = N-1):**
  - ybuf[i] ← (acc·N_INV) mod P.
  - step ← (step·W_INV) mod P.
  - acc ← 0, tw ← 1, j ← 0, i++.
  - The finalize cycle for i = N-1 moves the block to OUT with k = 0.
- **OUT:**
  - out_valid = 1 and out_data = ybuf[k].
  - out_last = (k == N-1).
  - Each handshake increments k.
  - The handshake with k = N-1 returns the block to LOAD.
- **Arithmetic:**
  - Products are formed at 2·WIDTH bits and reduced mod P.
  - Sums are formed at WIDTH+1 bits and reduced mod P.
  - All stored values are < P.
- **Input values ≥ P** are reduced on load; this is not an error.
- **in_valid outside LOAD** is ignored; in_ready = 0, so no data is lost.
- **Reset mid-operation:** an in-progress load, computation or output burst is aborted immediately. The next frame starts from j = 0.

## Timing
- in_ready is registered and asserts the first clock after reset release (IDLE→LOAD). Minimum frame load is N cycles.
- COMPUTE lasts exactly N·(N+1) cycles (72 for N=8). in_ready and out_valid are both 0 throughout.
- out_valid asserts the cycle after the last finalize. With out_ready held high, the N results take N cycles.
- out_data and out_last are stable while out_valid & !out_ready.
- in_ready reasserts the cycle after the out_last handshake. Total latency from last input handshake to first out_valid is N·(N+1)+1 cycles.
- busy is high from the cycle after the last input handshake through the out_last handshake cycle.

## Configuration
- **INTT_SCALE_EN defined:** the finalize step multiplies by N_INV, giving a true inverse transform.
- **INTT_SCALE_EN undefined:**
  - The finalize step stores acc unscaled (ybuf[i] ← acc), so the result is N times the inverse transform.
  - The N_INV multiplier is not instantiated.
  - Cycle timing is identical.

## Test plan
- **Impulse frame:** x = [8,0,0,0,0,0,0,0], P=17. With INTT_SCALE_EN: y = all 1. Without: y = all 8. out_last asserts on the 8th beat only.
- **Constant frame:** x = all 1. With INTT_SCALE_EN: y = [1,0,0,0,0,0,0,0]. Without: y = [8,0,...,0].
- **Round trip:** random x < 17 through a forward NTT model (ω=2), then through this block → output equals the original x.
  - Check first out_valid exactly 73 cycles after the last input handshake.
  - Check in_valid pulses during COMPUTE are ignored.
- **Backpressure:** out_ready toggles randomly and is held low 5 cycles on beat 3 → out_data and out_last are stable while stalled. No beat is lost or duplicated, and in_ready stays 0 until the out_last handshake.
- **Out-of-range input:** x = [25,0,...,0] → behaves identically to x = [8,0,...,0].
- **Reset mid-operation:** assert rst low during COMPUTE and again during OUT beat 4 → all outputs go to 0 asynchronously, in_ready = 1 one clock after release, and the next frame produces correct results.
